// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular {pc, instruction} FIFO between iFetch and iDecode
module if_id_queue #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD-1:0]            in_pc,
  input  logic [INSTR_LEN-1:0]       in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD-1:0]            out_pc,
  output logic [INSTR_LEN-1:0]       out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = WORD + INSTR_LEN;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_q != CW'(DEPTH)) & reset;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign head      = mem_q[rd_ptr_q];
  assign out_pc    = out_valid ? head[EW-1:INSTR_LEN] : '0;
  assign out_instr = out_valid ? head[INSTR_LEN-1:0] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A taken branch discards everything, including this cycle's push and pop.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; contents are only observable through count.
  always_ff @(posedge clk) begin
    if (reset && push && !flush) begin
      mem_q[wr_ptr_q] <= {in_pc, in_instr};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc;
  logic [31:0] in_instr, out_instr;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] pcs [5];
  logic [31:0] ins [5];

  if_id_queue #(.WORD(64), .INSTR_LEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins_w);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins_w;
  endtask

  initial begin
    pcs[0] = 64'd0;  ins[0] = 32'hF84402C9;
    pcs[1] = 64'd4;  ins[1] = 32'h8B09026A;
    pcs[2] = 64'd8;  ins[2] = 32'hCB0A028B;
    pcs[3] = 64'd12; ins[3] = 32'hF80602CB;
    pcs[4] = 64'd16; ins[4] = 32'hB4FFFF6B;

    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'd0, 32'd0);

    // 1. reset
    step(); step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_in_ready_held", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready_released", 64'(in_ready), 64'd1);

    // 2. two pushes with decode always ready
    out_ready = 1'b1;
    drive(1'b1, pcs[0], ins[0]);
    step();
    chk("t2_valid0", 64'(out_valid), 64'd1);
    chk("t2_pc0", out_pc, 64'd0);
    chk("t2_instr0", 64'(out_instr), 64'hF84402C9);
    drive(1'b1, pcs[1], ins[1]);
    step();
    chk("t2_count_mid", 64'(count), 64'd1);
    chk("t2_pc1", out_pc, 64'd4);
    chk("t2_instr1", 64'(out_instr), 64'h8B09026A);
    drive(1'b0, 64'd0, 32'd0);
    step();
    chk("t2_count_end", 64'(count), 64'd0);
    chk("t2_valid_end", 64'(out_valid), 64'd0);

    // 3. fill, refuse fifth push, drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pcs[i], ins[i]);
      step();
      chk("t3_fill_count", 64'(count), 64'(i + 1));
    end
    chk("t3_full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, pcs[4], ins[4]);
    step();
    chk("t3_refused_count", 64'(count), 64'd4);
    drive(1'b0, 64'd0, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_pc", out_pc, pcs[i]);
      chk("t3_drain_instr", 64'(out_instr), 64'(ins[i]));
      step();
    end
    chk("t3_drained_count", 64'(count), 64'd0);
    chk("t3_drained_valid", 64'(out_valid), 64'd0);

    // 4. steady push+pop at count 2 across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 64'h100 + 64'(4 * k), 32'hA000_0000 + 32'(k));
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_count", 64'(count), 64'd2);
      chk("t4_pc", out_pc, 64'h100 + 64'(4 * k));
      chk("t4_instr", 64'(out_instr), 64'hA000_0000 + 64'(k));
      drive(1'b1, 64'h100 + 64'(4 * (k + 2)), 32'hA000_0000 + 32'(k + 2));
      step();
    end
    drive(1'b0, 64'd0, 32'd0);
    for (int k = 10; k < 12; k++) begin
      chk("t4_tail_pc", out_pc, 64'h100 + 64'(4 * k));
      step();
    end
    chk("t4_end_count", 64'(count), 64'd0);

    // 5. flush with concurrent push and pop
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'h200 + 64'(4 * k), 32'hB000_0000 + 32'(k));
      step();
    end
    chk("t5_pre_count", 64'(count), 64'd3);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 64'd16, 32'hB4FFFF6B);
    #1;
    chk("t5_in_ready_flush", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    drive(1'b0, 64'd0, 32'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 64'h300, 32'hC0DE_0001);
    step();
    chk("t5_after_pc", out_pc, 64'h300);
    chk("t5_after_count", 64'(count), 64'd1);

    // 6. reset beats flush mid-operation
    for (int k = 1; k < 3; k++) begin
      drive(1'b1, 64'h300 + 64'(4 * k), 32'hC0DE_0001 + 32'(k));
      step();
    end
    chk("t6_pre_count", 64'(count), 64'd3);
    drive(1'b0, 64'd0, 32'd0);
    reset = 1'b0; flush = 1'b1;
    step();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1; flush = 1'b0;
    drive(1'b1, 64'd20, 32'h1234_5678);
    step();
    drive(1'b0, 64'd0, 32'd0);
    chk("t6_first_pc", out_pc, 64'd20);
    chk("t6_first_instr", 64'(out_instr), 64'h1234_5678);
    chk("t6_first_count", 64'(count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
